// File: rtl/screen_code_fsm.sv
// Screen/menu state machine producing the {screen, cursor} code read by the CPU PIO.
// Optional idle return-to-menu enabled by defining SCREEN_IDLE_TIMEOUT_EN.

module screen_code_debounce #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1_q, sync2_q, stable_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        // Level accepted; only a released->pressed flip yields an event.
        stable_q <= sync2_q;
        cnt_q    <= '0;
        press_q  <= stable_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module screen_code_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 1500000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  input  logic       game_over,
  output logic [4:0] code_screen,
  output logic       screen_changed
);
  localparam int KEY_SEL  = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_BACK = 3;

  typedef enum logic [2:0] {
    SCR_MENU    = 3'd0,
    SCR_PLAY    = 3'd1,
    SCR_PAUSE   = 3'd2,
    SCR_GOVER   = 3'd3,
    SCR_HELP    = 3'd4,
    SCR_CREDITS = 3'd5
  } screen_e;

  logic [3:0] press;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_key
      screen_code_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk     (clk),
        .rst_n   (reset_n),
        .key_n_i (key_n[g]),
        .press_o (press[g])
      );
    end
  endgenerate

  screen_e    scr_q, scr_d;
  logic [1:0] cur_q, cur_d;
  logic       chg_q, chg_d;
  logic       any_press;
  logic       ev_go, ev_back, ev_sel, ev_up, ev_down;
  logic       timeout;

  assign any_press = |press;

  // One event per cycle: game_over > back > select > up > down.
  always_comb begin
    ev_go   = game_over && (scr_q == SCR_PLAY);
    ev_back = !ev_go && press[KEY_BACK];
    ev_sel  = !ev_go && !press[KEY_BACK] && press[KEY_SEL];
    ev_up   = !ev_go && !press[KEY_BACK] && !press[KEY_SEL] && press[KEY_UP];
    ev_down = !ev_go && !press[KEY_BACK] && !press[KEY_SEL] && !press[KEY_UP] &&
              press[KEY_DOWN];
  end

`ifdef SCREEN_IDLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          idle_scr;

  assign idle_scr = (scr_q == SCR_HELP) || (scr_q == SCR_CREDITS) || (scr_q == SCR_GOVER);
  assign timeout  = idle_scr && !any_press && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = '0;
    if (idle_scr && !any_press && !chg_d) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    scr_d = scr_q;
    cur_d = cur_q;
    case (scr_q)
      SCR_MENU: begin
        if (ev_sel) begin
          cur_d = 2'd0;
          case (cur_q)
            2'd0:    scr_d = SCR_PLAY;
            2'd1:    scr_d = SCR_HELP;
            2'd2:    scr_d = SCR_CREDITS;
            default: scr_d = SCR_MENU;
          endcase
        end else if (ev_up) begin
          cur_d = (cur_q == 2'd0) ? 2'd2 : cur_q - 2'd1;
        end else if (ev_down) begin
          cur_d = (cur_q >= 2'd2) ? 2'd0 : cur_q + 2'd1;
        end
      end
      SCR_PLAY: begin
        if (ev_go) begin
          scr_d = SCR_GOVER;
          cur_d = 2'd0;
        end else if (ev_back) begin
          scr_d = SCR_PAUSE;
          cur_d = 2'd0;
        end
      end
      SCR_PAUSE: begin
        if (ev_back) begin
          scr_d = SCR_PLAY;
          cur_d = 2'd0;
        end else if (ev_sel) begin
          scr_d = (cur_q[0] == 1'b0) ? SCR_PLAY : SCR_MENU;
          cur_d = 2'd0;
        end else if (ev_up || ev_down) begin
          cur_d = {1'b0, ~cur_q[0]};
        end
      end
      SCR_GOVER: begin
        if (ev_sel) begin
          scr_d = SCR_MENU;
          cur_d = 2'd0;
        end
      end
      SCR_HELP: begin
        if (ev_back || ev_sel) begin
          scr_d = SCR_MENU;
          cur_d = 2'd1;
        end
      end
      SCR_CREDITS: begin
        if (ev_back || ev_sel) begin
          scr_d = SCR_MENU;
          cur_d = 2'd2;
        end
      end
      default: begin
        scr_d = SCR_MENU;
        cur_d = 2'd0;
      end
    endcase
    if (timeout) begin
      scr_d = SCR_MENU;
      cur_d = 2'd0;
    end
    chg_d = ({scr_d, cur_d} != {scr_q, cur_q});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scr_q <= SCR_MENU;
      cur_q <= 2'd0;
      chg_q <= 1'b0;
    end else begin
      scr_q <= scr_d;
      cur_q <= cur_d;
      chg_q <= chg_d;
    end
  end

  assign code_screen    = {scr_q, cur_q};
  assign screen_changed = chg_q;
endmodule

// File: tb/tb_screen_code_fsm.sv
// Directed bench for screen_code_fsm with short debounce (8) and timeout (20) settings.
module tb_screen_code_fsm;
  localparam int N = 8;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_n;
  logic       game_over;
  logic [4:0] code_screen;
  logic       screen_changed;

  int total = 0;
  int bad   = 0;
  int chg_cnt = 0;
  int c0;

  always #5 clk = ~clk;

  screen_code_fsm #(.DEBOUNCE_CYCLES(N), .TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_n          (key_n),
    .game_over      (game_over),
    .code_screen    (code_screen),
    .screen_changed (screen_changed)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chg_cnt += int'(screen_changed);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drops key k, waits for the full press latency, checks the new code and one pulse, releases.
  task automatic press(input int k, input logic [4:0] exp, input string tag);
    int s;
    s = chg_cnt;
    key_n[k] = 1'b0;
    step(N + 3);
    chk(tag, 32'(code_screen), 32'(exp));
    chk({tag, "_pulses"}, 32'(chg_cnt - s), 32'd1);
    key_n[k] = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    key_n     = 4'hF;
    game_over = 1'b0;
    step(3);
    chk("rst_code", 32'(code_screen), 32'h00);
    chk("rst_chg", 32'(screen_changed), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Exact latency of a select press: change at E0+2+N.
    c0 = chg_cnt;
    key_n[0] = 1'b0;
    step(N + 2);
    chk("sel_early", 32'(code_screen), 32'h00);
    step(1);
    chk("sel_play", 32'(code_screen), 32'h04);
    chk("sel_chg_hi", 32'(screen_changed), 32'd1);
    step(1);
    chk("sel_chg_lo", 32'(screen_changed), 32'd0);
    chk("sel_pulses", 32'(chg_cnt - c0), 32'd1);
    key_n[0] = 1'b1;

    press(3, 5'h08, "play_back_pause");
    press(2, 5'h09, "pause_down");
    press(0, 5'h00, "pause_sel_menu");
    press(1, 5'h02, "menu_up_wrap");
    press(0, 5'h14, "menu_sel_credits");
    press(3, 5'h02, "credits_back");
    press(2, 5'h00, "menu_down_wrap");

    // Bounce on up: short lows never reach the debounce count.
    c0 = chg_cnt;
    for (int r = 0; r < 4; r++) begin
      key_n[1] = 1'b0;
      step(5);
      key_n[1] = 1'b1;
      step(3);
    end
    chk("bounce_code", 32'(code_screen), 32'h00);
    chk("bounce_pulses", 32'(chg_cnt - c0), 32'd0);
    press(1, 5'h02, "bounce_hold_up");
    press(2, 5'h00, "menu_down_wrap2");
    press(0, 5'h04, "menu_sel_play");

    // game_over arrives in the same cycle as the back event.
    c0 = chg_cnt;
    key_n[3] = 1'b0;
    step(N + 2);
    chk("gover_pre", 32'(code_screen), 32'h04);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    chk("gover_code", 32'(code_screen), 32'h0C);
    chk("gover_pulses", 32'(chg_cnt - c0), 32'd1);
    key_n[3] = 1'b1;
    step(1);
    chk("gover_no_pause", 32'(code_screen), 32'h0C);
    c0 = chg_cnt;
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    step(2);
    chk("gover_again_code", 32'(code_screen), 32'h0C);
    chk("gover_again_pulses", 32'(chg_cnt - c0), 32'd0);
    press(0, 5'h00, "gover_sel_menu");

    // HELP idle behaviour.
    press(2, 5'h01, "menu_down_1");
    press(0, 5'h10, "menu_sel_help");
    step(T - 1);
    chk("help_before_to", 32'(code_screen), 32'h10);
    step(1);
`ifdef SCREEN_IDLE_TIMEOUT_EN
    chk("help_timeout", 32'(code_screen), 32'h00);
    chk("help_timeout_chg", 32'(screen_changed), 32'd1);
`else
    chk("help_persist", 32'(code_screen), 32'h10);
`endif

    // Reset in the middle of a debounce.
    key_n[0] = 1'b0;
    step(4);
    reset_n = 1'b0;
    #1;
    chk("midrst_code", 32'(code_screen), 32'h00);
    chk("midrst_chg", 32'(screen_changed), 32'd0);
    key_n[0] = 1'b1;
    step(2);
    reset_n = 1'b1;
    c0 = chg_cnt;
    step(N + 4);
    chk("postrst_code", 32'(code_screen), 32'h00);
    chk("postrst_pulses", 32'(chg_cnt - c0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/screen_code_fsm.md
# screen_code_fsm

Upstream producer of the 5-bit screen code sampled by the Nios II `codeScreen` PIO input port. It takes the four active-low board pushbuttons and a game-over strobe from the game logic. It synchronizes and debounces the buttons, then runs the game's screen/menu state machine. It drives a registered `{screen, cursor}` code that software reads to select what to render.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 2.
- `TIMEOUT_CYCLES`, default 1500000000: idle return-to-menu delay (30 s at 50 MHz); used only with `SCREEN_IDLE_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: system clock. This is the only clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `key_n`, input, 4: raw pushbuttons, active low, asynchronous. [0] select, [1] up, [2] down, [3] back/pause.
- `game_over`, input, 1: single-cycle pulse, synchronous to `clk`.
- `code_screen`, output, 5: `{screen[2:0], cursor[1:0]}`. Connects to the PIO `in_port`.
- `screen_changed`, output, 1: one-cycle pulse whenever `code_screen` changes value.

## Operation
- Input path, per key: a 2-FF synchronizer feeds a debounce counter.
  - The counter counts while the synchronized level differs from the stable level and clears when they are equal.
  - When the count reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
  - A press event is a stable 1→0 transition: one cycle wide, one per physical press. A release generates no event.
- Screen encoding:
  - MENU=0, PLAY=1, PAUSE=2, GAME_OVER=3, HELP=4, CREDITS=5.
  - Codes 6 and 7 are illegal and force MENU with cursor 0 on the next edge.
- Transitions:
  - MENU, up/down: move the cursor through 0..2, wrapping (up from 0 goes to 2; down from 2 goes to 0).
  - MENU, select: cursor 0 enters PLAY, 1 enters HELP, 2 enters CREDITS.
  - PLAY: back enters PAUSE with cursor 0. `game_over` enters GAME_OVER.
  - PAUSE, up/down: toggle the cursor between 0 and 1.
  - PAUSE, select: cursor 0 enters PLAY, cursor 1 enters MENU with cursor 0.
  - PAUSE, back: enters PLAY.
  - GAME_OVER, select: enters MENU with cursor 0.
  - HELP, back or select: enters MENU with cursor 1.
  - CREDITS, back or select: enters MENU with cursor 2.
- The cursor field is 0 in PLAY, GAME_OVER, HELP and CREDITS.
- Events with no listed transition are discarded. `game_over` is ignored outside PLAY.
- Simultaneous events: priority is `game_over` > back > select > up > down. Only the highest-priority event is acted on; the rest in that cycle are dropped.

## Timing
- Reset values:
  - `code_screen` = 5'b00000 (MENU, cursor 0).
  - `screen_changed` = 0.
  - All stable key levels = 1 (released); counters = 0.
- A key held through reset is seen as a new press once debounced after reset release.
- Key latency: let E0 be the edge at which the first synchronizer stage captures 0.
  - The stable level flips at edge E0+1+`DEBOUNCE_CYCLES`.
  - The event is high during the following cycle.
  - `code_screen` updates at edge E0+2+`DEBOUNCE_CYCLES`.
- A bounce (level returning before the count completes) clears the counter. No event is produced.
- `game_over` latency: `code_screen` updates at the edge after the pulse is sampled.
- `screen_changed` is registered and asserted in exactly the cycle in which the new `code_screen` value first appears. It is not asserted when an event leaves the code unchanged.
- Reset asserted mid-debounce or mid-timeout returns all state to reset values immediately (asynchronously).

## Configuration
- Macro: `SCREEN_IDLE_TIMEOUT_EN`.
- Defined:
  - In HELP, CREDITS and GAME_OVER, an idle counter counts cycles without a press event. Any press event clears it, including discarded ones.
  - Reaching `TIMEOUT_CYCLES` enters MENU with cursor 0 and pulses `screen_changed`.
  - The counter clears on every screen change.
- Undefined: no idle counter exists. These screens persist indefinitely and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Reset, then a clean press of `key_n[0]`. Response: `code_screen` goes 0x00 → 0x04 (PLAY) at E0+2+N, with one `screen_changed` pulse.
- In MENU, press up once. Response: cursor wraps to 2, code 0x02. Then press select: code 0x14 (CREDITS). Then press back: code 0x02.
- With N=8, toggle `key_n[1]` low for 5 cycles and high repeatedly (bounce). Response: no event, no code change. Then hold low for 10 cycles: exactly one event.
- In PLAY, pulse `game_over` in the same cycle a back event occurs. Response: code 0x0C (GAME_OVER), PAUSE not entered. Then `game_over` again: no change and no `screen_changed`.
- In PAUSE, press down (code 0x09), then select. Response: code 0x00. Assert `reset_n` low mid-debounce of a later press: code 0x00 and no event after release.
- With `SCREEN_IDLE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, in HELP with no presses: code 0x00 after 20 cycles. Without the macro: code stays 0x10.
